// File: rtl/led_pattern_sequencer_pkg.sv
// Shared types and reset-time defaults for the three-channel LED pattern sequencer.
package led_pattern_sequencer_pkg;

    localparam int unsigned PAT_W_DEF = 10;
    localparam int unsigned DIV_W_DEF = 4;
    localparam int unsigned N_CH      = 3;

    // Power-on patterns; bit 0 is shown on the first step.
    localparam logic [9:0] DEF_BAR   = 10'b0010011110;
    localparam logic [9:0] DEF_MOSCA = 10'b0110101100;
    localparam logic [9:0] DEF_AZUL  = 10'b1010101000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HOLD   = 2'd2,
        ST_FINISH = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        CH_BAR   = 2'd0,
        CH_MOSCA = 2'd1,
        CH_AZUL  = 2'd2,
        CH_NONE  = 2'd3
    } cfg_ch_t;

endpackage

// File: rtl/led_pattern_sequencer_step_prescaler.sv
// Step-period prescaler: tick fires once every div+1 enabled cycles.
module step_prescaler #(
    parameter int unsigned DIV_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // >= rather than == so a live decrease of div cannot strand the counter.
    assign tick = en && (cnt >= div);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt >= div) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Three-channel LED pattern sequencer: rotates per-channel patterns onto led at a divided step rate.
module led_pattern_sequencer
    import led_pattern_sequencer_pkg::*;
#(
    parameter int unsigned PAT_W = PAT_W_DEF,
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode_loop,
    input  logic [DIV_W-1:0] div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_ch,
    input  logic [PAT_W-1:0] cfg_pattern,
    output logic [2:0]       led,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(PAT_W + 1);

    seq_state_t       state;
    seq_state_t       next_state;
    logic [PAT_W-1:0] cfg_pat  [N_CH];
    logic [PAT_W-1:0] work_pat [N_CH];
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_wrap;
    logic             cfg_we;
    logic             load_w;
    logic             step;
    logic             pre_en;
    logic             pre_clr;
    logic             tick;

    assign cfg_we   = cfg_valid && cfg_ready;
    assign cnt_inc  = step_cnt + CNT_W'(1);
    assign cnt_wrap = (cnt_inc == CNT_W'(PAT_W));

    step_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (pre_en),
        .clr   (pre_clr),
        .div   (div),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Stop outranks start everywhere; a config load outranks start in IDLE.
    always_comb begin
        next_state = state;
        pre_en     = 1'b0;
        pre_clr    = 1'b0;
        load_w     = 1'b0;
        step       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!cfg_we && start && !stop) begin
                    next_state = ST_RUN;
                    pre_clr    = 1'b1;
                    load_w     = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    next_state = ST_HOLD;
                end else begin
                    pre_en = 1'b1;
                    if (tick) begin
                        step = 1'b1;
                        if (cnt_wrap && !mode_loop) begin
                            next_state = ST_FINISH;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (stop) begin
                    next_state = ST_IDLE;
                end else if (start) begin
                    next_state = ST_RUN;
                end
            end
            ST_FINISH: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Registered status outputs track the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            busy      <= (next_state == ST_RUN) || (next_state == ST_HOLD);
            done      <= (next_state == ST_FINISH);
            cfg_ready <= (next_state == ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cfg_pat[CH_BAR]    <= PAT_W'(DEF_BAR);
            cfg_pat[CH_MOSCA]  <= PAT_W'(DEF_MOSCA);
            cfg_pat[CH_AZUL]   <= PAT_W'(DEF_AZUL);
        end else if (cfg_we) begin
            case (cfg_ch)
                CH_BAR:   cfg_pat[CH_BAR]   <= cfg_pattern;
                CH_MOSCA: cfg_pat[CH_MOSCA] <= cfg_pattern;
                CH_AZUL:  cfg_pat[CH_AZUL]  <= cfg_pattern;
                default:  ;
            endcase
        end
    end

    // Working registers rotate right so bit 0 is always the lamp for the next step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            led                <= 3'b000;
            step_cnt           <= '0;
            work_pat[CH_BAR]   <= PAT_W'(DEF_BAR);
            work_pat[CH_MOSCA] <= PAT_W'(DEF_MOSCA);
            work_pat[CH_AZUL]  <= PAT_W'(DEF_AZUL);
        end else if (load_w) begin
            step_cnt <= '0;
            for (int i = 0; i < int'(N_CH); i++) begin
                work_pat[i] <= cfg_pat[i];
            end
        end else if (step) begin
            led      <= {work_pat[CH_BAR][0], work_pat[CH_MOSCA][0], work_pat[CH_AZUL][0]};
            step_cnt <= cnt_wrap ? '0 : cnt_inc;
            for (int i = 0; i < int'(N_CH); i++) begin
                work_pat[i] <= {work_pat[i][0], work_pat[i][PAT_W-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: vector table plus hand-written multi-cycle sequences.
module tb_led_pattern_sequencer;

    localparam int unsigned PAT_W = 10;
    localparam int unsigned DIV_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic             mode_loop;
    logic [DIV_W-1:0] div;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_ch;
    logic [PAT_W-1:0] cfg_pattern;
    logic [2:0]       led;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .PAT_W (PAT_W),
        .DIV_W (DIV_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .mode_loop   (mode_loop),
        .div         (div),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_pattern (cfg_pattern),
        .led         (led),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        logic             start;
        logic             stop;
        logic             cfg_valid;
        logic [1:0]       cfg_ch;
        logic [PAT_W-1:0] cfg_pattern;
        logic [2:0]       exp_led;
        logic             exp_busy;
        logic             exp_done;
        logic             exp_ready;
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] dflt [10];
    logic [2:0] bar1 [10];

    function automatic vec_t mk(input logic st, input logic sp, input logic cv,
                                input logic [1:0] ch, input logic [PAT_W-1:0] pat,
                                input logic [2:0] l, input logic b, input logic d,
                                input logic r);
        vec_t v;
        v.start = st; v.stop = sp; v.cfg_valid = cv; v.cfg_ch = ch; v.cfg_pattern = pat;
        v.exp_led = l; v.exp_busy = b; v.exp_done = d; v.exp_ready = r;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step_clk();
        reset = 1'b1;
    endtask

    task automatic chk_status(input string nm, input logic [2:0] l, input logic b,
                              input logic d, input logic r);
        chk({nm, "_led"},   32'(led),       32'(l));
        chk({nm, "_busy"},  32'(busy),      32'(b));
        chk({nm, "_done"},  32'(done),      32'(d));
        chk({nm, "_ready"}, 32'(cfg_ready), 32'(r));
    endtask

    // Runs a full single pass of the default patterns at div=0 from IDLE.
    task automatic run_default(input string nm);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        chk_status({nm, "_start"}, led, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step_clk();
            chk($sformatf("%s_step%0d_led", nm, k + 1), 32'(led), 32'(dflt[k]));
            chk($sformatf("%s_step%0d_done", nm, k + 1), 32'(done), 32'(k == 9));
        end
        step_clk();
        chk_status({nm, "_after"}, dflt[9], 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        dflt = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b100,
                 3'b011, 3'b000, 3'b111, 3'b010, 3'b001};
        // Same sequence with the bar channel loaded as all ones.
        bar1 = '{3'b100, 3'b100, 3'b110, 3'b111, 3'b100,
                 3'b111, 3'b100, 3'b111, 3'b110, 3'b101};

        reset = 1'b0; start = 1'b0; stop = 1'b0; mode_loop = 1'b0;
        div = '0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_pattern = '0;
        step_clk();
        step_clk();
        chk_status("reset", 3'b000, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;

        // Default pass, then a bar load that beats start, then two passes with the new bar.
        vecs.push_back(mk(1, 0, 0, 2'd0, '0, 3'b000, 1, 0, 0));
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk(0, 0, 0, 2'd0, '0, dflt[k], k < 9, k == 9, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, '0, 3'b001, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 2'd0, '1, 3'b001, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 2'd0, '0, 3'b001, 1, 0, 0));
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk(0, 0, k == 1, 2'd0, '0, bar1[k], k < 9, k == 9, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, '0, 3'b101, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 2'd0, '0, 3'b101, 1, 0, 0));
        for (int k = 0; k < 10; k++)
            vecs.push_back(mk(0, 0, 0, 2'd0, '0, bar1[k], k < 9, k == 9, 0));
        vecs.push_back(mk(0, 0, 0, 2'd0, '0, 3'b101, 0, 0, 1));

        foreach (vecs[i]) begin
            start       = vecs[i].start;
            stop        = vecs[i].stop;
            cfg_valid   = vecs[i].cfg_valid;
            cfg_ch      = vecs[i].cfg_ch;
            cfg_pattern = vecs[i].cfg_pattern;
            step_clk();
            chk_status($sformatf("vec%0d", i), vecs[i].exp_led, vecs[i].exp_busy,
                       vecs[i].exp_done, vecs[i].exp_ready);
        end
        start = 1'b0; cfg_valid = 1'b0;

        // div=3: bar alternates 0,1,0,... so each step is visible on led[2]; prior led[2]=1.
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_pattern = 10'b1010101010;
        step_clk();
        cfg_valid = 1'b0;
        div = 4'd3;
        start = 1'b1;
        step_clk();
        start = 1'b0;
        for (int e = 1; e < 16; e++) begin
            step_clk();
            chk($sformatf("div3_edge%0d", e), 32'(led[2]),
                32'((e < 4) ? 1'b1 : (((e / 4) % 2) == 1 ? 1'b0 : 1'b1)));
        end
        stop = 1'b1;
        step_clk();
        step_clk();
        stop = 1'b0;
        chk("div3_idle_busy", 32'(busy), 32'(0));
        div = '0;

        // Hold after step 3, resume, finish the pass.
        do_reset();
        start = 1'b1;
        step_clk();
        start = 1'b0;
        for (int k = 0; k < 3; k++) step_clk();
        chk("hold_step3", 32'(led), 32'(3'b110));
        stop = 1'b1;
        step_clk();
        stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step_clk();
            chk_status($sformatf("hold_c%0d", k), 3'b110, 1'b1, 1'b0, 1'b0);
        end
        start = 1'b1;
        step_clk();
        start = 1'b0;
        chk("resume_led", 32'(led), 32'(3'b110));
        for (int k = 3; k < 10; k++) begin
            step_clk();
            chk($sformatf("resume_step%0d", k + 1), 32'(led), 32'(dflt[k]));
        end
        chk("resume_done", 32'(done), 32'(1));
        step_clk();
        chk_status("resume_idle", 3'b001, 1'b0, 1'b0, 1'b1);

        // Loop mode for 25 steps, then start+stop together.
        do_reset();
        mode_loop = 1'b1;
        start = 1'b1;
        step_clk();
        start = 1'b0;
        for (int k = 0; k < 25; k++) begin
            step_clk();
            chk($sformatf("loop_step%0d", k + 1), 32'(led), 32'(dflt[k % 10]));
            chk($sformatf("loop_done%0d", k + 1), 32'(done), 32'(0));
        end
        start = 1'b1; stop = 1'b1;
        step_clk();
        chk_status("both_hold", dflt[4], 1'b1, 1'b0, 1'b0);
        start = 1'b0;
        step_clk();
        stop = 1'b0;
        chk_status("hold_stop_idle", dflt[4], 1'b0, 1'b0, 1'b1);
        mode_loop = 1'b0;

        // Reset mid-run at step 6, then a clean default pass.
        do_reset();
        start = 1'b1;
        step_clk();
        start = 1'b0;
        for (int k = 0; k < 6; k++) step_clk();
        chk("mid_step6", 32'(led), 32'(3'b011));
        reset = 1'b0;
        step_clk();
        reset = 1'b1;
        chk_status("mid_reset", 3'b000, 1'b0, 1'b0, 1'b1);
        run_default("rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

Interface
REQ-001 SHALL have parameter PAT_W, default 10, meaning pattern length in steps per channel.
REQ-002 SHALL have parameter DIV_W, default 4, meaning width of the step-period divider input.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-005 SHALL have port start, input, 1, level-sampled run request.
REQ-006 SHALL have port stop, input, 1, level-sampled halt request.
REQ-007 SHALL have port mode_loop, input, 1, where 1 means repeat patterns forever and 0 means one pass of PAT_W steps.
REQ-008 SHALL have port div, input, DIV_W, where step period = div+1 clk cycles.
REQ-009 SHALL have port cfg_valid, input, 1, pattern-load request.
REQ-010 SHALL have port cfg_ready, output, 1, pattern-load acceptance.
REQ-011 SHALL have port cfg_ch, input, 2, selecting the channel (0=bar, 1=mosca, 2=azul; 3=discard).
REQ-012 SHALL have port cfg_pattern, input, PAT_W, the pattern to load.
REQ-013 SHALL have port led, output, 3, {bar, mosca, azul} lamp drive.
REQ-014 SHALL have port busy, output, 1, high in RUN or HOLD.
REQ-015 SHALL have port done, output, 1, one-cycle pulse at the end of a single pass.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, HOLD, FINISH.
REQ-017 SHALL keep three config pattern registers and three working rotate registers.
REQ-018 SHALL, in IDLE with start=1 and stop=0, copy config to working registers, clear the prescaler and step count, and enter RUN.
REQ-019 SHALL, in RUN, increment the prescaler each cycle and fire a step when prescaler >= div, clearing it (so a live div decrease never stalls).
REQ-020 SHALL, on a step, set led <= {bar_w[0], mosca_w[0], azul_w[0]}, rotate each working register right by 1 ({x[0], x[PAT_W-1:1]}) and increment step count.
REQ-021 SHALL make the first led update occur on the (div+1)th rising edge after the edge that samples start in IDLE.
REQ-022 SHALL, when mode_loop=0, enter FINISH on the step that makes step count = PAT_W; FINISH lasts one cycle with done=1, then goes to IDLE.
REQ-023 SHALL, when mode_loop=1, wrap step count PAT_W-1 -> 0 and remain in RUN; done never asserts.
REQ-024 SHALL, on stop=1 in RUN, enter HOLD with the prescaler, step count, working registers and led frozen.
REQ-025 SHALL, on start=1 and stop=0 in HOLD, resume RUN without reloading; stop=1 in HOLD goes to IDLE.
REQ-026 SHALL give stop priority when start and stop are both high.
REQ-027 SHALL drive cfg_ready=1 only in IDLE; the handshake completes when cfg_valid and cfg_ready are both high, writing cfg_pattern into the cfg_ch register that cycle, with cfg_ch=3 accepted and discarded.
REQ-028 SHALL give a load priority over start in the same IDLE cycle: the load completes and start is ignored that cycle.
REQ-029 SHALL hold led at its last value in IDLE, HOLD and FINISH.
REQ-030 SHALL sample mode_loop live; clearing it mid-loop ends the run when step count next reaches PAT_W.

Reset
REQ-031 SHALL, with reset=0 at a clk edge, force state=IDLE, led=000, done=0, busy=0, prescaler=0 and step count=0, including mid-run.
REQ-032 SHALL restore the config registers on reset to bar=0010011110, mosca=0110101100, azul=1010101000, with the working registers set to the same values.

Structure
REQ-033 SHALL place the state encoding, PAT_W/DIV_W defaults and the three default patterns in a shared package/include.
REQ-034 SHALL implement the prescaler as sub-module step_prescaler (inputs clk, reset, en, clr, div; output tick).

Verification
REQ-035 SHALL verify: reset, div=0, mode_loop=0, start pulse -> led over steps 1..10 = 000,100,110,111,100,011,000,111,010,001; done high exactly one cycle after step 10; busy low afterwards.
REQ-036 SHALL verify: div=3 -> led changes every 4 cycles, with the first change 4 edges after start is sampled.
REQ-037 SHALL verify: load cfg_ch=0 with 1111111111 in IDLE, then run -> led[2]=1 on every step; a load attempted during RUN -> cfg_ready=0 and the pattern is unchanged.
REQ-038 SHALL verify: stop after step 3 -> led stays 110 and busy=1 in HOLD; start -> step 4 gives 111 and steps continue to 10.
REQ-039 SHALL verify: mode_loop=1 for 25 steps -> step 11 repeats step 1 (000) and done is never asserted; start and stop together in RUN -> HOLD.
REQ-040 SHALL verify: reset=0 asserted at step 6 -> the next edge gives led=000 and IDLE; the following run reproduces the REQ-035 default sequence.
